// File: rtl/ans_pkg.sv
// Shared definitions for the ANS encoder slice: default widths, controller FSM
// encoding and a saturating counter helper.
package ans_pkg;

    localparam int CNT_WIDTH   = 8;
    localparam int STATE_WIDTH = 16;
    localparam int SYM_WIDTH   = 4;

    typedef enum logic [2:0] {
        ST_CONFIG = 3'd0,
        ST_PREFIX = 3'd1,
        ST_READY  = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_CHECK  = 3'd4
    } ctrl_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ans_freq_table.sv
// Per-symbol frequency table with a sequential prefix-sum engine producing the
// cumulative-count table and the total count, one entry per cycle.
module ans_freq_table #(
    parameter int NUM_SYMS    = 16,
    parameter int IDX_WIDTH   = 4,
    parameter int CNT_WIDTH   = ans_pkg::CNT_WIDTH,
    parameter int STATE_WIDTH = ans_pkg::STATE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   we,
    input  logic [IDX_WIDTH-1:0]   wr_addr,
    input  logic [CNT_WIDTH-1:0]   wr_count,
    input  logic                   start,
    input  logic [IDX_WIDTH-1:0]   rd_idx,
    output logic [CNT_WIDTH-1:0]   rd_count,
    output logic [STATE_WIDTH-1:0] rd_cum,
    output logic [STATE_WIDTH-1:0] total,
    output logic                   prefix_busy,
    output logic                   prefix_ovf
);

    logic [CNT_WIDTH-1:0]   count_q [NUM_SYMS];
    logic [STATE_WIDTH-1:0] cum_q   [NUM_SYMS];
    logic [STATE_WIDTH:0]   acc_q;
    logic [STATE_WIDTH:0]   acc_next;
    logic [IDX_WIDTH-1:0]   idx_q;
    logic [STATE_WIDTH-1:0] total_q;
    logic                   busy_q;
    logic                   ovf_q;

    // The accumulator carries one extra bit so an overflow of STATE_WIDTH is visible.
    assign acc_next = acc_q + {{(STATE_WIDTH + 1 - CNT_WIDTH){1'b0}}, count_q[idx_q]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SYMS; i++) begin
                count_q[i] <= '0;
                cum_q[i]   <= '0;
            end
            acc_q   <= '0;
            idx_q   <= '0;
            total_q <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (ena) begin
            if (we) begin
                count_q[wr_addr] <= wr_count;
            end
            // Entry 0 is resolved in the start cycle so the sweep finishes in NUM_SYMS cycles.
            if (start) begin
                cum_q[0] <= '0;
                acc_q    <= {{(STATE_WIDTH + 1 - CNT_WIDTH){1'b0}}, count_q[0]};
                idx_q    <= IDX_WIDTH'(1);
                busy_q   <= 1'b1;
                ovf_q    <= 1'b0;
            end else if (busy_q) begin
                cum_q[idx_q] <= acc_q[STATE_WIDTH-1:0];
                acc_q        <= acc_next;
                ovf_q        <= ovf_q | acc_next[STATE_WIDTH];
                idx_q        <= idx_q + IDX_WIDTH'(1);
                if (idx_q == IDX_WIDTH'(NUM_SYMS - 1)) begin
                    busy_q <= 1'b0;
                    if (!(ovf_q | acc_next[STATE_WIDTH])) begin
                        total_q <= acc_next[STATE_WIDTH-1:0];
                    end
                end
            end
        end
    end

    assign rd_count    = count_q[rd_idx];
    assign rd_cum      = cum_q[rd_idx];
    assign total       = total_q;
    assign prefix_busy = busy_q;
    assign prefix_ovf  = ovf_q;

endmodule

// File: rtl/ans_enc_ctrl.sv
// Sequencing controller for ans_encoder: frequency table, symbol issue and
// renormalization retry. Optional counters via ANS_CTRL_STATS_EN.
module ans_enc_ctrl import ans_pkg::*; #(
    parameter int NUM_SYMS    = 16,
    parameter int IDX_WIDTH   = 4,
    parameter int CNT_WIDTH   = ans_pkg::CNT_WIDTH,
    parameter int STATE_WIDTH = ans_pkg::STATE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   cfg_we,
    input  logic [IDX_WIDTH-1:0]   cfg_addr,
    input  logic [CNT_WIDTH-1:0]   cfg_count,
    input  logic                   cfg_done,
    output logic                   cfg_err,
    input  logic [IDX_WIDTH-1:0]   sym_idx,
    input  logic                   sym_last,
    input  logic                   sym_vld,
    output logic                   sym_rdy,
    output logic [CNT_WIDTH-1:0]   enc_s_count,
    output logic [STATE_WIDTH-1:0] enc_s_cumulative,
    output logic [STATE_WIDTH-1:0] enc_total_count,
    output logic                   enc_in_vld,
    input  logic                   enc_in_rdy,
    input  logic                   enc_out_vld,
    input  logic [3:0]             enc_out,
    output logic                   enc_out_rdy,
    output logic [3:0]             out,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   sym_err,
    output logic                   done,
`ifdef ANS_CTRL_STATS_EN
    output logic [15:0]            stat_syms,
    output logic [15:0]            stat_nibbles,
`endif
    output ctrl_state_t            dbg_state
);

    // Handshakes: a transfer happens on a cycle where both vld and rdy are high;
    // a vld source holds its payload stable until that cycle.

    ctrl_state_t            state_q;
    logic [IDX_WIDTH-1:0]   idx_q;
    logic                   last_q;
    logic                   renorm_q;
    logic [IDX_WIDTH-1:0]   rd_idx;
    logic [CNT_WIDTH-1:0]   rd_count;
    logic [STATE_WIDTH-1:0] rd_cum;
    logic [STATE_WIDTH-1:0] total;
    logic                   prefix_busy;
    logic                   prefix_ovf;
    logic                   tbl_we;
    logic                   tbl_start;
    logic                   consume;

    assign tbl_we    = cfg_we && (state_q == ST_CONFIG);
    assign tbl_start = cfg_done && (state_q == ST_CONFIG);
    assign rd_idx    = (state_q == ST_READY) ? sym_idx : idx_q;
    assign consume   = (state_q == ST_CHECK) && !enc_out_vld && !renorm_q;

    ans_freq_table #(
        .NUM_SYMS    (NUM_SYMS),
        .IDX_WIDTH   (IDX_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH),
        .STATE_WIDTH (STATE_WIDTH)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .we          (tbl_we),
        .wr_addr     (cfg_addr),
        .wr_count    (cfg_count),
        .start       (tbl_start),
        .rd_idx      (rd_idx),
        .rd_count    (rd_count),
        .rd_cum      (rd_cum),
        .total       (total),
        .prefix_busy (prefix_busy),
        .prefix_ovf  (prefix_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_CONFIG;
            idx_q            <= '0;
            last_q           <= 1'b0;
            renorm_q         <= 1'b0;
            sym_rdy          <= 1'b0;
            enc_in_vld       <= 1'b0;
            enc_s_count      <= '0;
            enc_s_cumulative <= '0;
            cfg_err          <= 1'b0;
            sym_err          <= 1'b0;
            done             <= 1'b0;
        end else if (!ena) begin
            // Frozen: hold everything, but never stretch a pulse.
            sym_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            sym_err <= 1'b0;
            done    <= 1'b0;
            case (state_q)
                ST_CONFIG: begin
                    if (cfg_done) begin
                        cfg_err <= 1'b0;
                        state_q <= ST_PREFIX;
                    end
                end
                ST_PREFIX: begin
                    if (!prefix_busy) begin
                        if ((total == '0) || prefix_ovf) begin
                            cfg_err <= 1'b1;
                            state_q <= ST_CONFIG;
                        end else begin
                            sym_rdy <= 1'b1;
                            state_q <= ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    if (sym_vld) begin
                        idx_q  <= sym_idx;
                        last_q <= sym_last;
                        if (rd_count == '0) begin
                            sym_err <= 1'b1;
                            done    <= sym_last;
                        end else begin
                            sym_rdy          <= 1'b0;
                            enc_in_vld       <= 1'b1;
                            enc_s_count      <= rd_count;
                            enc_s_cumulative <= rd_cum;
                            state_q          <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (enc_in_rdy) begin
                        enc_in_vld <= 1'b0;
                        state_q    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // renorm_q remembers that a nibble came out, so its drain is not read as consumption.
                    if (enc_out_vld) begin
                        renorm_q <= 1'b1;
                    end else if (renorm_q) begin
                        renorm_q   <= 1'b0;
                        enc_in_vld <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end else begin
                        sym_rdy <= 1'b1;
                        done    <= last_q;
                        state_q <= ST_READY;
                    end
                end
                default: state_q <= ST_CONFIG;
            endcase
        end
    end

`ifdef ANS_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_syms    <= '0;
            stat_nibbles <= '0;
        end else if (ena) begin
            if (cfg_done) begin
                stat_syms    <= '0;
                stat_nibbles <= '0;
            end else begin
                if (consume) begin
                    stat_syms <= sat_inc16(stat_syms);
                end
                if (enc_out_vld && out_rdy) begin
                    stat_nibbles <= sat_inc16(stat_nibbles);
                end
            end
        end
    end
`endif

    assign enc_total_count = total;
    assign out             = enc_out;
    assign out_vld         = enc_out_vld;
    assign enc_out_rdy     = out_rdy;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_ans_enc_ctrl.sv
// Directed bench for ans_enc_ctrl with a scoreboard of expected issue payloads.
module tb_ans_enc_ctrl;
    import ans_pkg::*;

    logic        clk = 1'b0;
    logic        rst, ena;
    logic        cfg_we, cfg_done, cfg_err;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_count;
    logic [3:0]  sym_idx;
    logic        sym_last, sym_vld, sym_rdy;
    logic [7:0]  enc_s_count;
    logic [15:0] enc_s_cumulative, enc_total_count;
    logic        enc_in_vld, enc_in_rdy, enc_out_vld, enc_out_rdy;
    logic [3:0]  enc_out, out;
    logic        out_vld, out_rdy, sym_err, done;
    ctrl_state_t dbg_state;
`ifdef ANS_CTRL_STATS_EN
    logic [15:0] stat_syms, stat_nibbles;
`endif

    int          checks = 0;
    int          errors = 0;
    int          consumed = 0;
    int          nibbles = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  model_cnt [16];

    ans_enc_ctrl dut (
        .clk(clk), .rst(rst), .ena(ena),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_count(cfg_count),
        .cfg_done(cfg_done), .cfg_err(cfg_err),
        .sym_idx(sym_idx), .sym_last(sym_last), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
        .enc_s_count(enc_s_count), .enc_s_cumulative(enc_s_cumulative),
        .enc_total_count(enc_total_count), .enc_in_vld(enc_in_vld),
        .enc_in_rdy(enc_in_rdy), .enc_out_vld(enc_out_vld),
        .enc_out(enc_out), .enc_out_rdy(enc_out_rdy),
        .out(out), .out_vld(out_vld), .out_rdy(out_rdy),
        .sym_err(sym_err), .done(done),
`ifdef ANS_CTRL_STATS_EN
        .stat_syms(stat_syms), .stat_nibbles(stat_nibbles),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_cum(input int idx);
        logic [15:0] s = '0;
        for (int i = 0; i < idx; i++) s += 16'(model_cnt[i]);
        return s;
    endfunction

    task automatic push_sym(input int idx);
        exp_q.push_back({model_cnt[idx], model_cum(idx)});
    endtask

    task automatic issue_check(input string tag);
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed issue with empty scoreboard expected none", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {8'h0, enc_s_count, enc_s_cumulative}, {8'h0, e});
        end
    endtask

    task automatic cfg_write(input int addr, input logic [7:0] cnt);
        cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_count = cnt;
        model_cnt[addr] = cnt;
        tick();
        cfg_we = 1'b0;
    endtask

    // Plain symbol with the encoder consuming it without renormalization.
    task automatic run_sym(input int idx, input string tag);
        sym_idx = 4'(idx); sym_last = 1'b0; sym_vld = 1'b1;
        push_sym(idx);
        tick();
        sym_vld = 1'b0;
        issue_check(tag);
        tick();
        tick();
        check({tag, "_ready"}, 32'(sym_rdy), 32'd1);
        consumed++;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_count = '0; cfg_done = 1'b0;
        sym_idx = '0; sym_last = 1'b0; sym_vld = 1'b0;
        enc_in_rdy = 1'b1; enc_out_vld = 1'b0; enc_out = '0; out_rdy = 1'b0;
        for (int i = 0; i < 16; i++) model_cnt[i] = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_state", 32'(dbg_state), 32'(ST_CONFIG));
        check("rst_sym_rdy", 32'(sym_rdy), 32'd0);
        check("rst_in_vld", 32'(enc_in_vld), 32'd0);
        check("rst_flags", {29'd0, cfg_err, sym_err, done}, 32'd0);
        check("rst_total", 32'(enc_total_count), 32'd0);

        // All counts zero: prefix must fail back to CONFIG.
        cfg_done = 1'b1; tick(); cfg_done = 1'b0;
        check("zero_prefix_state", 32'(dbg_state), 32'(ST_PREFIX));
        repeat (15) tick();
        check("zero_prefix_late", 32'(dbg_state), 32'(ST_PREFIX));
        tick();
        check("zero_cfg_err", 32'(cfg_err), 32'd1);
        check("zero_state", 32'(dbg_state), 32'(ST_CONFIG));
        check("zero_sym_rdy", 32'(sym_rdy), 32'd0);

        cfg_write(0, 8'd3);
        cfg_write(1, 8'd1);
        cfg_done = 1'b1; tick(); cfg_done = 1'b0;
        check("cfg_err_clear", 32'(cfg_err), 32'd0);
        repeat (15) tick();
        check("prefix_rdy_early", 32'(sym_rdy), 32'd0);
        tick();
        check("prefix_rdy", 32'(sym_rdy), 32'd1);
        check("prefix_state", 32'(dbg_state), 32'(ST_READY));
        check("prefix_total", 32'(enc_total_count), 32'd4);

        // Symbol 1 consumed without renormalization.
        sym_idx = 4'd1; sym_last = 1'b0; sym_vld = 1'b1;
        push_sym(1);
        tick();
        sym_vld = 1'b0;
        check("s1_issue_state", 32'(dbg_state), 32'(ST_ISSUE));
        check("s1_in_vld", 32'(enc_in_vld), 32'd1);
        issue_check("s1_payload");
        tick();
        check("s1_check_in_vld", 32'(enc_in_vld), 32'd0);
        tick();
        check("s1_ready", 32'(sym_rdy), 32'd1);
        check("s1_done", 32'(done), 32'd0);
        consumed++;

        // Symbol 0 (last) with encoder back-pressure and one renormalization.
        sym_idx = 4'd0; sym_last = 1'b1; sym_vld = 1'b1;
        push_sym(0);
        tick();
        sym_vld = 1'b0; sym_last = 1'b0;
        issue_check("s0_payload");
        enc_in_rdy = 1'b0;
        tick();
        check("s0_issue_hold", {23'd0, enc_in_vld, enc_s_count}, {23'd0, 1'b1, 8'd3});
        enc_in_rdy = 1'b1;
        tick();
        check("s0_check_in_vld", 32'(enc_in_vld), 32'd0);
        enc_out_vld = 1'b1; enc_out = 4'hA; out_rdy = 1'b0;
        #1;
        check("pass_out", {27'd0, out_vld, out}, {27'd0, 1'b1, 4'hA});
        check("pass_rdy_low", 32'(enc_out_rdy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_in_vld", {28'd0, enc_in_vld, 3'(dbg_state)}, {28'd0, 1'b0, 3'(ST_CHECK)});
        end
        out_rdy = 1'b1;
        #1;
        check("pass_rdy_high", 32'(enc_out_rdy), 32'd1);
        tick();
        nibbles++;
        enc_out_vld = 1'b0; out_rdy = 1'b0;
        push_sym(0);
        tick();
        check("reissue_in_vld", 32'(enc_in_vld), 32'd1);
        issue_check("reissue_payload");
        tick();
        tick();
        check("s0_done", {30'd0, done, sym_rdy}, 32'd3);
        consumed++;
        tick();
        check("s0_done_pulse", 32'(done), 32'd0);

        // Zero-count symbol with sym_last: dropped with sym_err and done together.
        sym_idx = 4'd5; sym_last = 1'b1; sym_vld = 1'b1;
        tick();
        sym_vld = 1'b0; sym_last = 1'b0;
        check("s5_err_done", {30'd0, sym_err, done}, 32'd3);
        check("s5_no_issue", {29'd0, enc_in_vld, sym_rdy, 1'b0}, {29'd0, 1'b0, 1'b1, 1'b0});
        tick();
        check("s5_pulse_end", {30'd0, sym_err, done}, 32'd0);

        // Enable low: a valid symbol is not accepted.
        sym_idx = 4'd1; sym_vld = 1'b1; ena = 1'b0;
        tick();
        check("ena_hold", 32'(dbg_state), 32'(ST_READY));
        ena = 1'b1;
        sym_vld = 1'b0;
        run_sym(1, "ena_resume");

        for (int i = 0; i < 4; i++) run_sym($urandom_range(0, 1), "rand_sym");

`ifdef ANS_CTRL_STATS_EN
        check("stat_syms", 32'(stat_syms), 32'(consumed));
        check("stat_nibbles", 32'(stat_nibbles), 32'(nibbles));
`endif

        // Reset while waiting in CHECK on a renormalization.
        sym_idx = 4'd1; sym_vld = 1'b1;
        push_sym(1);
        tick();
        sym_vld = 1'b0;
        issue_check("rst_path_payload");
        tick();
        enc_out_vld = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; enc_out_vld = 1'b0;
        check("mid_rst_state", 32'(dbg_state), 32'(ST_CONFIG));
        check("mid_rst_outs", {28'd0, sym_rdy, enc_in_vld, cfg_err, done}, 32'd0);
        check("mid_rst_payload", {enc_s_count, enc_s_cumulative, 8'd0}, 32'd0);
        check("mid_rst_total", 32'(enc_total_count), 32'd0);
`ifdef ANS_CTRL_STATS_EN
        check("mid_rst_stat", 32'(stat_syms), 32'd0);
`endif
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ans_enc_ctrl.md
# ans_enc_ctrl

Sequencing controller for the `ans_encoder` datapath. It holds a per-symbol frequency table and derives the cumulative-count table and total count from it. It accepts a stream of symbol indices, drives the encoder's `s_count`/`s_cumulative`/`total_count`/`in_vld`, and re-presents a symbol until the encoder actually consumes it rather than renormalizing. It sits between the symbol source and one `ans_encoder`, and passes the encoder's nibble output through to the downstream sink.

## Interface
Parameters:
- `NUM_SYMS`, 16, alphabet size (power of two).
- `IDX_WIDTH`, 4, log2(NUM_SYMS).
- `CNT_WIDTH`, 8, per-symbol count width; equals `` `CNT_WIDTH ``.
- `STATE_WIDTH`, 16, cumulative/total width; equals `` `STATE_WIDTH ``.

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — synchronous, active-high reset.
- `ena` in 1 — global enable; all state holds when low.
- `cfg_we` in 1, `cfg_addr` in IDX_WIDTH, `cfg_count` in CNT_WIDTH — frequency-table write.
- `cfg_done` in 1 — pulse: table complete, start prefix sum.
- `cfg_err` out 1 — sticky: total count zero or overflowed STATE_WIDTH.
- `sym_idx` in IDX_WIDTH, `sym_last` in 1, `sym_vld` in 1, `sym_rdy` out 1 — symbol stream.
- `enc_s_count` out CNT_WIDTH, `enc_s_cumulative` out STATE_WIDTH, `enc_total_count` out STATE_WIDTH, `enc_in_vld` out 1, `enc_in_rdy` in 1, `enc_out_vld` in 1 — encoder control.
- `enc_out` in 4, `enc_out_rdy` out 1; `out` out 4, `out_vld` out 1, `out_rdy` in 1 — nibble pass-through.
- `sym_err` out 1 — one-cycle pulse: zero-count symbol dropped.
- `done` out 1 — one-cycle pulse after the `sym_last` symbol is consumed.

## Operation
- FSM states: CONFIG, PREFIX, READY, ISSUE, CHECK.
- CONFIG:
  - `cfg_we` writes `count[cfg_addr]`.
  - `cfg_done` moves to PREFIX.
  - `cfg_we` in any other state is ignored.
- PREFIX:
  - One entry per cycle, i = 0..NUM_SYMS-1: `cum[i] = sum(count[0..i-1])`.
  - Final sum goes to `total`.
  - If `total == 0` or the sum exceeds STATE_WIDTH, set `cfg_err` and go to CONFIG; otherwise go to READY.
- READY:
  - `sym_rdy = 1`.
  - On `sym_vld`: latch `sym_idx` and `sym_last`.
  - If `count[idx] == 0`: pulse `sym_err`, drop the symbol, stay in READY. If `sym_last` was set, also pulse `done`.
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive `enc_s_count = count[idx]` and `enc_s_cumulative = cum[idx]`; assert `enc_in_vld`.
  - Go to CHECK on the cycle `enc_in_rdy` is high.
- CHECK:
  - `enc_in_vld = 0`.
  - `enc_out_vld == 1` means the encoder renormalized. Wait until the nibble is taken (`enc_out_vld` low), then return to ISSUE with the same symbol.
  - `enc_out_vld == 0` means the symbol was consumed. Go to READY; pulse `done` if the latched `sym_last` was set.
- `enc_total_count = total` at all times. It is 0 until the first successful PREFIX.
- Pass-through: `out = enc_out`, `out_vld = enc_out_vld`, `enc_out_rdy = out_rdy`, all combinational.
- `cfg_err` clears on the next `cfg_done`.

## Timing
- Reset values:
  - State CONFIG.
  - Count and cum tables cleared; `total = 0`.
  - `sym_rdy`, `enc_in_vld`, `cfg_err`, `sym_err`, `done` all 0.
- PREFIX takes exactly NUM_SYMS cycles after the `cfg_done` cycle. `sym_rdy` first rises on the next cycle.
- Symbol with no renormalization, consumed in 3 cycles: accept (READY) → ISSUE handshake → CHECK.
- Each renormalization adds 2 cycles plus downstream stall: CHECK wait → re-ISSUE.
- `enc_s_count` and `enc_s_cumulative` are registered and stable from ISSUE entry until leaving CHECK.
- `sym_vld` together with `sym_rdy = 0` has no effect.
- Reset mid-stream: everything returns to reset values in the next cycle. The encoder must be reset alongside.
- `ena` low freezes the FSM. Outputs hold and pulses do not repeat.

## Configuration
- `ANS_CTRL_STATS_EN` defined:
  - Adds outputs `stat_syms` (16 bits, consumed symbols) and `stat_nibbles` (16 bits, nibbles accepted downstream, i.e. `out_vld & out_rdy`).
  - Both counters saturate at 0xFFFF and clear on reset and on `cfg_done`.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `ans_pkg`:
  - FSM state encoding.
  - Default widths: `CNT_WIDTH`, `STATE_WIDTH`, `SYM_WIDTH` = 4.
  - Also shared with `ans_encoder`.
- One sub-module, `ans_freq_table`:
  - Count and cum register arrays, write port and sequential prefix-sum engine.
  - Outputs: read port (count, cum by index), `total`, `prefix_busy`, overflow flag.

## Test plan
- Reset, then write count[0]=3, count[1]=1, rest 0, and pulse `cfg_done` → after 16 cycles `sym_rdy=1`, `enc_total_count=4`, `cum[1]=3`, `cum[2]=4`.
- All counts 0 and `cfg_done` → `cfg_err=1`, FSM in CONFIG, `sym_rdy` stays 0.
- Symbol 1 with encoder model not renormalizing → `enc_s_count=1`, `enc_s_cumulative=3`, one `enc_in_vld` handshake, back in READY 3 cycles after accept.
- Symbol forcing renormalization, `out_rdy` held low 5 cycles → `enc_in_vld` low during the stall, same symbol reissued after the nibble is taken, `out` equals `enc_out`.
- Symbol 5 (count 0) with `sym_last=1` → `sym_err` and `done` pulse in the same cycle, no `enc_in_vld`.
- `rst` asserted during CHECK → next cycle all outputs at reset values, state CONFIG; with `ANS_CTRL_STATS_EN`, `stat_syms=0`.
